// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and default operand width.
package seq_signed_divider_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/seq_signed_divider_div_step.sv
// One unsigned restoring-division step: shift in the next dividend bit,
// try to subtract the divisor magnitude, keep the result if no borrow.
module div_step
    import seq_signed_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0] rem_in,
    input  logic       bit_in,
    input  logic [N:0] dmag,
    output logic [N:0] rem_out,
    output logic       q_bit
);

    logic [N+1:0] shifted_s;
    logic [N+1:0] trial_s;

    // Trial subtraction; the top bit of the difference is the borrow.
    always_comb begin
        shifted_s = {rem_in, bit_in};
        trial_s   = shifted_s - {1'b0, dmag};
        q_bit     = ~trial_s[N+1];
        if (q_bit) begin
            rem_out = trial_s[N:0];
        end else begin
            rem_out = shifted_s[N:0];
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (2N-bit / N-bit) built on an unsigned restoring
// core with sign fix-up, overflow and divide-by-zero detection.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [2*N-1:0] dividend,
    input  logic signed [N-1:0]   divisor,
    output logic signed [N-1:0]   quotient,
    output logic signed [N-1:0]   remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CW = $clog2(2*N) + 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(2*N - 1);
    localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] QMAG_POS  = (2*N)'(2**(N-1) - 1);
    localparam logic [2*N-1:0] QMAG_NEG  = (2*N)'(2**(N-1));

    state_t state_r;
    state_t state_s;

    logic [2*N-1:0] dvd_r;
    logic [N-1:0]   dvs_r;
    logic [2*N-1:0] acc_q_r;
    logic [N:0]     rem_r;
    logic [N:0]     dmag_r;
    logic           sd_r;
    logic           sq_r;
    logic [CW-1:0]  cnt_r;

    logic [N-1:0]   quotient_r;
    logic [N-1:0]   remainder_r;
    logic           busy_r;
    logic           done_r;
    logic           ovf_r;
    logic           dbz_r;

    logic [2*N:0]   dvd_ext_s;
    logic [2*N-1:0] dvd_mag_s;
    logic [N:0]     dvs_ext_s;
    logic [N:0]     dvs_mag_s;
    logic [N:0]     step_rem_s;
    logic           step_q_s;
    logic           dbz_s;
    logic           ovf_s;
    logic [N-1:0]   q_signed_s;
    logic [N-1:0]   r_signed_s;

    div_step #(.N(N)) u_step (
        .rem_in  (rem_r),
        .bit_in  (acc_q_r[2*N-1]),
        .dmag    (dmag_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: fixed LOAD, 2N x CALC, FIX, DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: state_s = CALC;
            CALC: begin
                if (cnt_r == LAST_STEP) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Magnitudes are widened by one bit so the most-negative operands do not wrap.
    always_comb begin
        dvd_ext_s = {dvd_r[2*N-1], dvd_r};
        dvs_ext_s = {dvs_r[N-1], dvs_r};
        if (dvd_r[2*N-1]) begin
            dvd_mag_s = (2*N)'(-dvd_ext_s);
        end else begin
            dvd_mag_s = (2*N)'(dvd_ext_s);
        end
        if (dvs_r[N-1]) begin
            dvs_mag_s = -dvs_ext_s;
        end else begin
            dvs_mag_s = dvs_ext_s;
        end
    end

    // Sign fix-up and range check on the finished magnitude quotient.
    always_comb begin
        dbz_s = (dmag_r == {(N+1){1'b0}});
        if (dbz_s) begin
            ovf_s = 1'b0;
        end else if (sq_r) begin
            ovf_s = (acc_q_r > QMAG_NEG);
        end else begin
            ovf_s = (acc_q_r > QMAG_POS);
        end
        if (sq_r) begin
            q_signed_s = N'(-acc_q_r);
        end else begin
            q_signed_s = acc_q_r[N-1:0];
        end
        if (sd_r) begin
            r_signed_s = N'(-rem_r);
        end else begin
            r_signed_s = N'(rem_r);
        end
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_r       <= '0;
            dvs_r       <= '0;
            acc_q_r     <= '0;
            rem_r       <= '0;
            dmag_r      <= '0;
            sd_r        <= 1'b0;
            sq_r        <= 1'b0;
            cnt_r       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                    end
                end
                LOAD: begin
                    acc_q_r <= dvd_mag_s;
                    rem_r   <= '0;
                    dmag_r  <= dvs_mag_s;
                    sd_r    <= dvd_r[2*N-1];
                    sq_r    <= dvd_r[2*N-1] ^ dvs_r[N-1];
                    cnt_r   <= '0;
                end
                CALC: begin
                    acc_q_r <= {acc_q_r[2*N-2:0], step_q_s};
                    rem_r   <= step_rem_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    if (dbz_s || ovf_s) begin
                        quotient_r  <= '0;
                        remainder_r <= '0;
                    end else begin
                        quotient_r  <= q_signed_s;
                        remainder_r <= r_signed_s;
                    end
                    ovf_r <= ovf_s;
                    dbz_r <= dbz_s;
                end
                default: begin
                end
            endcase
        end
    end

    // busy covers cycles 1..2N+2 after acceptance; done follows the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == CALC) || (state_s == FIX) || (state_s == DONE);
            done_r <= (state_r == DONE);
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ovf       = ovf_r;
    assign dbz       = dbz_r;

endmodule
